// File: rtl/mips_run_ctrl_pkg.sv
// Shared definitions for the MIPS run controller.
//   run_state_e : controller FSM states
//   DEF_*       : default parameter values used by the interface and the top
//   cnt_width() : bits needed to hold a counter value in 0..max_val
package mips_run_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StRun,
        StDone,
        StTimeout
    } run_state_e;

    localparam int unsigned DEF_PC_W        = 32;
    localparam int unsigned DEF_CNT_W       = 32;
    localparam int unsigned DEF_RST_CYCLES  = 4;
    localparam int unsigned DEF_HALT_REPEAT = 8;
    localparam int unsigned DEF_MAX_CYCLES  = 100000;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mips_run_ctrl_if.sv
// Handshake/status bundle between the run harness and the run controller.
//   start        : pulse, begins a run from IDLE, DONE or TIMEOUT
//   commit_valid : core retired an instruction this cycle
//   commit_pc    : PC of the retired instruction
//   cpu_reset    : active-high synchronous reset to the core
//   cpu_en       : core clock-enable
//   running      : controller is in RUN
//   done         : halt (self-loop) detected, sticky until next start
//   timeout      : cycle budget exhausted, sticky until next start
//   cycle_count  : RUN cycles elapsed
//   retire_count : commits seen in RUN
// master = harness/core side, slave = controller side.
interface mips_run_ctrl_if
    import mips_run_ctrl_pkg::*;
#(
    parameter int unsigned PC_W  = DEF_PC_W,
    parameter int unsigned CNT_W = DEF_CNT_W
);

    logic             start;
    logic             commit_valid;
    logic [PC_W-1:0]  commit_pc;
    logic             cpu_reset;
    logic             cpu_en;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retire_count;

    modport master (
        output start, commit_valid, commit_pc,
        input  cpu_reset, cpu_en, running, done, timeout, cycle_count, retire_count
    );

    modport slave (
        input  start, commit_valid, commit_pc,
        output cpu_reset, cpu_en, running, done, timeout, cycle_count, retire_count
    );

endinterface

// File: rtl/mips_run_ctrl_repeat_detect.sv
// pc_repeat_detect: self-loop detector for the run controller.
// Tracks the last committed PC and how many times in a row it has been re-committed.
// halt is a combinational pulse: high on the commit that makes the same PC appear
// HALT_REPEAT times in a row.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : forget the last PC and the repeat count
//   commit       : a commit counted for halt detection (already gated to RUN)
//   commit_pc    : PC of that commit
//   halt         : this commit completes the self-loop
module pc_repeat_detect
    import mips_run_ctrl_pkg::*;
#(
    parameter int unsigned PC_W        = DEF_PC_W,
    parameter int unsigned HALT_REPEAT = DEF_HALT_REPEAT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            commit,
    input  logic [PC_W-1:0] commit_pc,
    output logic            halt
);

    localparam int unsigned RW = cnt_width(HALT_REPEAT - 1);
    // Count value just before the final matching commit.
    localparam logic [RW-1:0] HIT_PREV = RW'(HALT_REPEAT - 2);

    logic [PC_W-1:0] last_pc_q;
    logic            last_pc_valid_q;
    logic [RW-1:0]   repeat_q;
    logic            match;

    assign match = last_pc_valid_q && (commit_pc == last_pc_q);
    assign halt  = commit && match && (repeat_q == HIT_PREV);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_pc_q       <= '0;
            last_pc_valid_q <= 1'b0;
            repeat_q        <= '0;
        end else if (clear) begin
            last_pc_valid_q <= 1'b0;
            repeat_q        <= '0;
        end else if (commit) begin
            repeat_q        <= match ? repeat_q + 1'b1 : '0;
            last_pc_q       <= commit_pc;
            last_pc_valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined MIPS core.
// Sequences the core reset, counts RUN cycles and retired instructions, detects
// program end as a self-loop (same PC committed HALT_REPEAT times in a row) and
// aborts with a timeout after MAX_CYCLES RUN cycles. All outputs are registered.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset, forces IDLE
//   bus     : mips_run_ctrl_if.slave (start/commit in, core control and status out)
module mips_run_ctrl
    import mips_run_ctrl_pkg::*;
#(
    parameter int unsigned PC_W        = DEF_PC_W,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
    parameter int unsigned HALT_REPEAT = DEF_HALT_REPEAT,
    parameter int unsigned MAX_CYCLES  = DEF_MAX_CYCLES
) (
    input  logic           clk,
    input  logic           reset_n,
    mips_run_ctrl_if.slave bus
);

    localparam int unsigned      RCW      = cnt_width(RST_CYCLES - 1);
    localparam logic [RCW-1:0]   RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_CYCLES - 1);

    run_state_e       state_q;
    logic [RCW-1:0]   rst_cnt_q;
    logic             cpu_reset_q;
    logic             cpu_en_q;
    logic             running_q;
    logic             done_q;
    logic             timeout_q;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] retire_q;

    logic in_run;
    logic run_commit;
    logic halt;

    assign in_run     = (state_q == StRun);
    assign run_commit = in_run && bus.commit_valid;

    // Detector state is held cleared for the whole reset phase, so each run starts fresh.
    pc_repeat_detect #(
        .PC_W        (PC_W),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_repeat (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (state_q == StRst),
        .commit    (run_commit),
        .commit_pc (bus.commit_pc),
        .halt      (halt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            rst_cnt_q   <= '0;
            cpu_reset_q <= 1'b1;
            cpu_en_q    <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cycle_q     <= '0;
            retire_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone, StTimeout: begin
                    if (bus.start) begin
                        state_q     <= StRst;
                        rst_cnt_q   <= '0;
                        cpu_reset_q <= 1'b1;
                        cpu_en_q    <= 1'b1;
                        running_q   <= 1'b0;
                        done_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                        cycle_q     <= '0;
                        retire_q    <= '0;
                    end
                end
                StRst: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_q     <= StRun;
                        cpu_reset_q <= 1'b0;
                        running_q   <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    // The exit edge still counts its cycle and commit, so the final
                    // counts include the qualifying cycle.
                    cycle_q <= cycle_q + 1'b1;
                    if (bus.commit_valid) begin
                        retire_q <= retire_q + 1'b1;
                    end
                    if (halt) begin
                        state_q   <= StDone;
                        cpu_en_q  <= 1'b0;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (cycle_q == MAX_LAST) begin
                        state_q   <= StTimeout;
                        cpu_en_q  <= 1'b0;
                        running_q <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.cpu_reset    = cpu_reset_q;
    assign bus.cpu_en       = cpu_en_q;
    assign bus.running      = running_q;
    assign bus.done         = done_q;
    assign bus.timeout      = timeout_q;
    assign bus.cycle_count  = cycle_q;
    assign bus.retire_count = retire_q;

    // Terminal flags are mutually exclusive and the core is frozen while either is set.
    a_flags_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(done_q && timeout_q));
    a_frozen_when_ended: assert property (@(posedge clk) disable iff (!reset_n)
        (done_q || timeout_q) |-> !cpu_en_q);

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: two instances (MAX_CYCLES 50 and 20) share one stimulus
// stream and are checked every cycle against a behavioural model, plus a directed
// vector table and hand-written corner-case sequences.
module tb_mips_run_ctrl;
    import mips_run_ctrl_pkg::*;

    localparam int unsigned RST_CYCLES  = 4;
    localparam int unsigned HALT_REPEAT = 8;
    localparam int unsigned MAX_A       = 50;
    localparam int unsigned MAX_B       = 20;

    localparam int MIdle = 0;
    localparam int MRst  = 1;
    localparam int MRun  = 2;
    localparam int MDone = 3;
    localparam int MTo   = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        cv = 1'b0;
    logic [31:0] pc = '0;

    always #5 clk = ~clk;

    mips_run_ctrl_if #(.PC_W(32), .CNT_W(32)) ifa ();
    mips_run_ctrl_if #(.PC_W(32), .CNT_W(32)) ifb ();

    assign ifa.start        = start;
    assign ifa.commit_valid = cv;
    assign ifa.commit_pc    = pc;
    assign ifb.start        = start;
    assign ifb.commit_valid = cv;
    assign ifb.commit_pc    = pc;

    mips_run_ctrl #(
        .PC_W(32), .CNT_W(32), .RST_CYCLES(RST_CYCLES),
        .HALT_REPEAT(HALT_REPEAT), .MAX_CYCLES(MAX_A)
    ) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifa.slave)
    );

    mips_run_ctrl #(
        .PC_W(32), .CNT_W(32), .RST_CYCLES(RST_CYCLES),
        .HALT_REPEAT(HALT_REPEAT), .MAX_CYCLES(MAX_B)
    ) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifb.slave)
    );

    // Behavioural model: one entry per instance.
    int          m_mode[2];
    int          m_rst_left[2];
    int unsigned m_cyc[2];
    int unsigned m_ret[2];
    int          m_streak[2];
    logic [31:0] m_last[2];
    bit          m_have[2];
    int unsigned m_max[2];

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i]     = MIdle;
            m_rst_left[i] = 0;
            m_cyc[i]      = 0;
            m_ret[i]      = 0;
            m_streak[i]   = 0;
            m_last[i]     = '0;
            m_have[i]     = 1'b0;
        end
    endtask

    // One clock edge of the model, using the inputs presented before the edge.
    task automatic model_step(input bit s, input bit c, input logic [31:0] p);
        bit halt;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            case (m_mode[i])
                MIdle, MDone, MTo: begin
                    if (s) begin
                        m_mode[i]     = MRst;
                        m_rst_left[i] = RST_CYCLES;
                        m_cyc[i]      = 0;
                        m_ret[i]      = 0;
                        m_streak[i]   = 0;
                        m_have[i]     = 1'b0;
                    end
                end
                MRst: begin
                    m_rst_left[i]--;
                    if (m_rst_left[i] == 0) m_mode[i] = MRun;
                end
                MRun: begin
                    halt = 1'b0;
                    if (c) begin
                        if (m_have[i] && p == m_last[i]) m_streak[i]++;
                        else m_streak[i] = 1;
                        m_last[i] = p;
                        m_have[i] = 1'b1;
                        m_ret[i]++;
                        halt = (m_streak[i] >= HALT_REPEAT);
                    end
                    m_cyc[i]++;
                    if (halt) m_mode[i] = MDone;
                    else if (m_cyc[i] == m_max[i]) m_mode[i] = MTo;
                end
                default: m_mode[i] = MIdle;
            endcase
        end
    endtask

    task automatic check_inst(input int i, input logic a_rst, input logic a_en,
                              input logic a_run, input logic a_done, input logic a_to,
                              input logic [31:0] a_cyc, input logic [31:0] a_ret);
        chk($sformatf("cpu_reset[%0d]", i), 32'(a_rst),
            32'(m_mode[i] == MIdle || m_mode[i] == MRst));
        chk($sformatf("cpu_en[%0d]", i), 32'(a_en),
            32'(m_mode[i] == MRst || m_mode[i] == MRun));
        chk($sformatf("running[%0d]", i), 32'(a_run), 32'(m_mode[i] == MRun));
        chk($sformatf("done[%0d]", i), 32'(a_done), 32'(m_mode[i] == MDone));
        chk($sformatf("timeout[%0d]", i), 32'(a_to), 32'(m_mode[i] == MTo));
        chk($sformatf("cycle_count[%0d]", i), a_cyc, m_cyc[i]);
        chk($sformatf("retire_count[%0d]", i), a_ret, m_ret[i]);
    endtask

    task automatic check_model();
        check_inst(0, ifa.cpu_reset, ifa.cpu_en, ifa.running, ifa.done, ifa.timeout,
                   ifa.cycle_count, ifa.retire_count);
        check_inst(1, ifb.cpu_reset, ifb.cpu_en, ifb.running, ifb.done, ifb.timeout,
                   ifb.cycle_count, ifb.retire_count);
    endtask

    // Called at posedge+1: drive inputs, take an edge, check at posedge+1.
    task automatic tick(input bit s, input bit c, input logic [31:0] p);
        start = s;
        cv    = c;
        pc    = p;
        @(posedge clk);
        model_step(s, c, p);
        #1;
        check_model();
    endtask

    // Asynchronous reset between edges; start is held high while reset is low.
    task automatic async_reset();
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_model();
        chk("async cpu_reset", 32'(ifa.cpu_reset), 32'(1'b1));
        chk("async running", 32'(ifa.running), 32'(1'b0));
        start = 1'b1;
        @(posedge clk);
        model_step(1'b1, 1'b0, '0);
        #1;
        check_model();
        #2;
        reset_n = 1'b1;
        start   = 1'b0;
    endtask

    typedef struct {
        bit          s;
        bit          c;
        logic [31:0] p;
        logic [3:0]  f;     // {cpu_reset, cpu_en, running, done}
        logic [31:0] cyc;
        logic [31:0] ret;
    } vec_t;

    vec_t tbl[20];

    task automatic set_vec(input int k, input bit s, input bit c, input logic [31:0] p,
                           input logic [3:0] f, input logic [31:0] cyc,
                           input logic [31:0] ret);
        tbl[k].s   = s;
        tbl[k].c   = c;
        tbl[k].p   = p;
        tbl[k].f   = f;
        tbl[k].cyc = cyc;
        tbl[k].ret = ret;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc_cur;

        m_max[0] = MAX_A;
        m_max[1] = MAX_B;

        // Start pulse, RST for 4 cycles, commits ending in 8x 0x300C with a gap.
        set_vec(0,  1'b0, 1'b0, 32'h0,    4'b1000, 32'd0,  32'd0);
        set_vec(1,  1'b1, 1'b0, 32'h0,    4'b1100, 32'd0,  32'd0);
        set_vec(2,  1'b1, 1'b0, 32'h0,    4'b1100, 32'd0,  32'd0);
        set_vec(3,  1'b0, 1'b0, 32'h0,    4'b1100, 32'd0,  32'd0);
        set_vec(4,  1'b0, 1'b1, 32'h2FFC, 4'b1100, 32'd0,  32'd0);
        set_vec(5,  1'b0, 1'b0, 32'h0,    4'b0110, 32'd0,  32'd0);
        set_vec(6,  1'b0, 1'b1, 32'h3000, 4'b0110, 32'd1,  32'd1);
        set_vec(7,  1'b0, 1'b1, 32'h3004, 4'b0110, 32'd2,  32'd2);
        set_vec(8,  1'b0, 1'b1, 32'h3008, 4'b0110, 32'd3,  32'd3);
        set_vec(9,  1'b0, 1'b1, 32'h300C, 4'b0110, 32'd4,  32'd4);
        set_vec(10, 1'b0, 1'b1, 32'h300C, 4'b0110, 32'd5,  32'd5);
        set_vec(11, 1'b0, 1'b1, 32'h300C, 4'b0110, 32'd6,  32'd6);
        set_vec(12, 1'b0, 1'b1, 32'h300C, 4'b0110, 32'd7,  32'd7);
        set_vec(13, 1'b0, 1'b0, 32'h300C, 4'b0110, 32'd8,  32'd7);
        set_vec(14, 1'b0, 1'b1, 32'h300C, 4'b0110, 32'd9,  32'd8);
        set_vec(15, 1'b0, 1'b1, 32'h300C, 4'b0110, 32'd10, 32'd9);
        set_vec(16, 1'b0, 1'b1, 32'h300C, 4'b0110, 32'd11, 32'd10);
        set_vec(17, 1'b0, 1'b1, 32'h300C, 4'b0001, 32'd12, 32'd11);
        set_vec(18, 1'b0, 1'b1, 32'h300C, 4'b0001, 32'd12, 32'd11);
        set_vec(19, 1'b1, 1'b0, 32'h0,    4'b1100, 32'd0,  32'd0);

        model_reset();
        #12;
        check_model();
        reset_n = 1'b1;

        for (int k = 0; k < 20; k++) begin
            tick(tbl[k].s, tbl[k].c, tbl[k].p);
            chk($sformatf("vec%0d flags", k),
                32'({ifa.cpu_reset, ifa.cpu_en, ifa.running, ifa.done}), 32'(tbl[k].f));
            chk($sformatf("vec%0d timeout", k), 32'(ifa.timeout), 32'(1'b0));
            chk($sformatf("vec%0d cycle_count", k), ifa.cycle_count, tbl[k].cyc);
            chk($sformatf("vec%0d retire_count", k), ifa.retire_count, tbl[k].ret);
        end

        // Interrupted loop: 7x 0x300C, then 0x3010 must itself repeat 8 times in a row.
        repeat (RST_CYCLES) tick(1'b0, 1'b0, '0);
        chk("restart running", 32'(ifa.running), 32'(1'b1));
        repeat (7) tick(1'b0, 1'b1, 32'h300C);
        repeat (7) tick(1'b0, 1'b1, 32'h3010);
        chk("no early done", 32'(ifa.done), 32'(1'b0));
        tick(1'b0, 1'b1, 32'h3010);
        chk("loop done", 32'(ifa.done), 32'(1'b1));
        chk("loop retire", ifa.retire_count, 32'd15);

        // Runaway program: PC never repeats.
        tick(1'b1, 1'b0, '0);
        repeat (RST_CYCLES) tick(1'b0, 1'b0, '0);
        for (int i = 0; i < 55; i++) tick(1'b0, 1'b1, 32'h4000 + 32'(4 * i));
        chk("to50 timeout", 32'(ifa.timeout), 32'(1'b1));
        chk("to50 done", 32'(ifa.done), 32'(1'b0));
        chk("to50 cycle_count", ifa.cycle_count, 32'd50);
        chk("to50 cpu_en", 32'(ifa.cpu_en), 32'(1'b0));
        chk("to20 cycle_count", ifb.cycle_count, 32'd20);
        tick(1'b1, 1'b0, '0);
        chk("restart cycle_count", ifa.cycle_count, 32'd0);
        chk("restart timeout", 32'(ifa.timeout), 32'(1'b0));
        chk("restart cpu_reset", 32'(ifa.cpu_reset), 32'(1'b1));

        // Halt lands in the last budget cycle of the MAX_CYCLES=20 instance.
        repeat (RST_CYCLES) tick(1'b0, 1'b0, '0);
        repeat (12) tick(1'b0, 1'b0, '0);
        repeat (8) tick(1'b0, 1'b1, 32'h5000);
        chk("tie done", 32'(ifb.done), 32'(1'b1));
        chk("tie timeout", 32'(ifb.timeout), 32'(1'b0));
        chk("tie cycle_count", ifb.cycle_count, 32'd20);

        // Asynchronous reset in the middle of RUN.
        tick(1'b1, 1'b0, '0);
        repeat (RST_CYCLES + 3) tick(1'b0, 1'b1, 32'h6000);
        async_reset();
        chk("post reset cpu_en", 32'(ifa.cpu_en), 32'(1'b0));
        tick(1'b0, 1'b0, '0);

        // Random traffic with a small PC pool so self-loops occur.
        pc_cur = 32'h100;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
            end
            if ($urandom_range(0, 7) == 0) pc_cur = 32'h100 + 32'(4 * $urandom_range(0, 3));
            tick($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, pc_cur);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
